// File: rtl/stopwatch_core_if.sv
// Stopwatch control/display bundle between the button front-end and the core.
// master: drives the button pulses, preset and direction; observes the display outputs.
// slave : the stopwatch core.
// Signals: start_stop, lap, clear, load (single-cycle pulses), load_value (preset),
//          up_down (direction), number (display value), running, lap_active,
//          expired (pulse), overflow (pulse).
interface stopwatch_core_if #(
   parameter int unsigned WIDTH = 16
) ();
   logic             start_stop;
   logic             lap;
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             up_down;
   logic [WIDTH-1:0] number;
   logic             running;
   logic             lap_active;
   logic             expired;
   logic             overflow;

   modport master (
      output start_stop, lap, clear, load, load_value, up_down,
      input  number, running, lap_active, expired, overflow
   );

   modport slave (
      input  start_stop, lap, clear, load, load_value, up_down,
      output number, running, lap_active, expired, overflow
   );
endinterface

// File: rtl/stopwatch_core.sv
// Stopwatch/timer core: run/pause/expire FSM, tick prescaler, per-digit decimal or
// base-6 up/down counting, countdown-from-preset with expiry, and a lap-freeze display.
// Ports: clk, rst_n (async active-low), bus (stopwatch_core_if.slave) carrying the
//        button pulses, preset, direction and the registered display/status outputs.
module stopwatch_core #(
   parameter int unsigned                  NUMBER_OF_DIGITS            = 4,
   parameter int unsigned                  NUMBER_OF_BITS_PER_DIGIT    = 4,
   parameter int unsigned                  BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
   parameter int unsigned                  TICK_FREQUENCY_IN_HZ        = 100,
   parameter logic [NUMBER_OF_DIGITS-1:0]  BASE6_DIGIT_MASK            = 4'b1000,
   parameter bit                           SATURATE                    = 1'b1
) (
   input logic             clk,
   input logic             rst_n,
   stopwatch_core_if.slave bus
);

   localparam int unsigned D          = NUMBER_OF_DIGITS;
   localparam int unsigned B          = NUMBER_OF_BITS_PER_DIGIT;
   localparam int unsigned W          = D * B;
   localparam int unsigned DIV        = BOARD_CLOCK_FREQUENCY_IN_HZ / TICK_FREQUENCY_IN_HZ;
   localparam int unsigned PW         = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RUNNING = 2'd1;
   localparam logic [1:0] PAUSED  = 2'd2;
   localparam logic [1:0] EXPIRED = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [W-1:0]  count_q, count_d;
   logic [W-1:0]  lap_q, lap_d;
   logic          lap_active_q, lap_active_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [W-1:0]  number_q;
   logic          running_q, expired_q, overflow_q;
   logic          expired_d, overflow_d;

   logic [W-1:0]  inc_c, dec_c, clamp_c;
   logic          carry_c, borrow_c, zero_c, tick_c;

   // Largest value a digit may hold: 5 for base-6 digits, 9 otherwise.
   function automatic logic [B-1:0] digit_max(input int unsigned idx);
      logic [D-1:0] m;
      m = BASE6_DIGIT_MASK >> idx;
      return m[0] ? B'(5) : B'(9);
   endfunction

   assign zero_c = (count_q == '0);
   assign tick_c = (state_q == RUNNING) && (presc_q == PRESC_LAST);

   // Ripple increment/decrement; carry_c ends high only when every digit was at its max.
   always_comb begin
      inc_c    = count_q;
      dec_c    = count_q;
      carry_c  = 1'b1;
      borrow_c = 1'b1;
      for (int unsigned i = 0; i < D; i++) begin
         if (carry_c) begin
            if (count_q[i*B +: B] == digit_max(i)) begin
               inc_c[i*B +: B] = '0;
            end else begin
               inc_c[i*B +: B] = count_q[i*B +: B] + B'(1);
               carry_c         = 1'b0;
            end
         end
         if (borrow_c) begin
            if (count_q[i*B +: B] == '0) begin
               dec_c[i*B +: B] = digit_max(i);
            end else begin
               dec_c[i*B +: B] = count_q[i*B +: B] - B'(1);
               borrow_c        = 1'b0;
            end
         end
      end
   end

   // Preset with every digit clamped to its legal range.
   always_comb begin
      clamp_c = '0;
      for (int unsigned i = 0; i < D; i++) begin
         if (bus.load_value[i*B +: B] > digit_max(i)) clamp_c[i*B +: B] = digit_max(i);
         else                                         clamp_c[i*B +: B] = bus.load_value[i*B +: B];
      end
   end

   // Next-state logic; pulse priority is clear > load > start_stop > lap.
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      lap_d        = lap_q;
      lap_active_d = lap_active_q;
      presc_d      = presc_q;
      overflow_d   = 1'b0;

      if (bus.clear) begin
         state_d      = IDLE;
         count_d      = '0;
         presc_d      = '0;
         lap_active_d = 1'b0;
      end else if (bus.load) begin
         count_d      = clamp_c;
         presc_d      = '0;
         lap_active_d = 1'b0;
         state_d      = ((clamp_c == '0) && !bus.up_down) ? IDLE : PAUSED;
      end else begin
         if (state_q == RUNNING) begin
            presc_d = tick_c ? '0 : presc_q + PW'(1);
            if (tick_c) begin
               if (bus.up_down) begin
                  if (!carry_c) begin
                     count_d = inc_c;
                  end else if (SATURATE) begin
                     state_d = EXPIRED;
                  end else begin
                     count_d    = '0;
                     overflow_d = 1'b1;
                  end
               end else begin
                  // A down-tick from zero also expires rather than wrapping to all-max.
                  count_d = zero_c ? '0 : dec_c;
                  if (zero_c || (dec_c == '0)) state_d = EXPIRED;
               end
            end
         end

         if (bus.start_stop) begin
            case (state_q)
               IDLE, PAUSED: if (!(zero_c && !bus.up_down)) state_d = RUNNING;
               // The coinciding tick is already applied; an expiry it causes wins.
               RUNNING:      if (state_d == RUNNING) state_d = PAUSED;
               default:      ;
            endcase
         end else if (bus.lap && ((state_q == RUNNING) || (state_q == PAUSED))) begin
            if (lap_active_q) begin
               lap_active_d = 1'b0;
            end else begin
               lap_d        = count_q;
               lap_active_d = 1'b1;
            end
         end
      end

      expired_d = (state_d == EXPIRED) && (state_q != EXPIRED);
   end

   // State and registered outputs; number tracks the same edge as count/lap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         count_q      <= '0;
         lap_q        <= '0;
         lap_active_q <= 1'b0;
         presc_q      <= '0;
         number_q     <= '0;
         running_q    <= 1'b0;
         expired_q    <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         lap_q        <= lap_d;
         lap_active_q <= lap_active_d;
         presc_q      <= presc_d;
         number_q     <= lap_active_d ? lap_d : count_d;
         running_q    <= (state_d == RUNNING);
         expired_q    <= expired_d;
         overflow_q   <= overflow_d;
      end
   end

   assign bus.number     = number_q;
   assign bus.running    = running_q;
   assign bus.lap_active = lap_active_q;
   assign bus.expired    = expired_q;
   assign bus.overflow   = overflow_q;

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
Parametrised stopwatch/timer datapath that generalises the fixed up/down digit counter. It adds a run/pause/expire state machine, an internal tick prescaler, per-digit modulus (decimal or base-6 for seconds/minutes tens), countdown-from-preset with expiry, and a lap-freeze display register. It sits between the debounced/edge-detected buttons and Display_Digits; `number` feeds the display and LEDs directly.

Parameters:
NUMBER_OF_DIGITS, 4, number of BCD digits; digit 0 is least significant.
NUMBER_OF_BITS_PER_DIGIT, 4, width of each digit field; must be >= 4.
BOARD_CLOCK_FREQUENCY_IN_HZ, 100_000_000, clk frequency.
TICK_FREQUENCY_IN_HZ, 100, rate of the least-significant digit increment; 100 gives hundredths.
BASE6_DIGIT_MASK, 4'b1000, bit i = 1 means digit i counts 0..5, otherwise 0..9.
SATURATE, 1, 1 = hold at the limit and expire when counting up; 0 = wrap to all-zero and pulse `overflow`.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start_stop  input  1  single-cycle pulse; toggles run/pause
lap  input  1  single-cycle pulse; toggles the lap freeze
clear  input  1  single-cycle pulse; returns to IDLE with the count at zero
load  input  1  single-cycle pulse; loads `load_value` into the count
load_value  input  D*B  preset value; D = NUMBER_OF_DIGITS, B = NUMBER_OF_BITS_PER_DIGIT
up_down  input  1  1 = count up, 0 = count down; sampled on each tick
number  output  D*B  displayed value: the live count, or the lap snapshot while frozen
running  output  1  high while in RUNNING
lap_active  output  1  high while the display is frozen
expired  output  1  one-cycle pulse on entry to EXPIRED
overflow  output  1  one-cycle pulse when an up-count wraps (SATURATE=0 only)

Behaviour:
- Reset (rst_n = 0, asynchronous) sets:
  - count = 0, lap register = 0, prescaler = 0, state = IDLE
  - all outputs = 0
- Tick generation:
  - Prescaler counts 0..(BOARD_CLOCK_FREQUENCY_IN_HZ / TICK_FREQUENCY_IN_HZ − 1) only in RUNNING; its terminal count is the tick.
  - The prescaler holds its value in PAUSED (resume keeps the partial period).
  - clear and load zero the prescaler.
- States:
  - IDLE: start_stop → RUNNING, except when up_down = 0 and count = 0, in which case start_stop is ignored.
  - RUNNING:
    - start_stop → PAUSED.
    - Down-tick that produces 0 → EXPIRED, with the count left at 0.
    - Up-tick at all-digits-max: if SATURATE = 1, hold the count and go to EXPIRED; if SATURATE = 0, wrap the count to 0, pulse `overflow` and stay in RUNNING.
  - PAUSED: start_stop → RUNNING (subject to the same zero/down rule as IDLE).
  - EXPIRED: holds the count; start_stop is ignored; only clear or load leave it.
- `expired` is registered: it is high for the cycle after the tick that causes EXPIRED.
- Arithmetic, per tick:
  - Digit 0 ± 1. A digit at its max (9, or 5 if its mask bit is set) rolls to 0 on up and carries.
  - A digit at 0 rolls to its max on down and borrows.
  - Carry/borrow ripples combinationally within the same cycle; the count register updates in the tick cycle.
  - Upper bits of each digit field beyond bit 3 are always 0.
- load:
  - Each load_value digit is clamped to its digit max.
  - Goes to PAUSED; if the loaded value is 0 and up_down = 0, goes to IDLE instead.
- Lap:
  - In RUNNING or PAUSED, lap with lap_active = 0 copies the count into the lap register and sets lap_active.
  - lap with lap_active = 1 clears lap_active.
  - Lap is ignored in IDLE and EXPIRED.
  - Counting continues unaffected while frozen.
- number = lap_active ? lap register : count. It is registered, so it reflects a count change 1 cycle after the tick.
- Simultaneous pulses, priority clear > load > start_stop > lap; lower-priority pulses in the same cycle are dropped. clear and load also clear lap_active.
- A tick coinciding with start_stop (RUNNING → PAUSED) is applied before pausing.
- up_down changes mid-run take effect on the next tick; a changed value never produces a double step.

Test Plan:
All scenarios use BOARD_CLOCK_FREQUENCY_IN_HZ = 10, TICK_FREQUENCY_IN_HZ = 1 (tick every 10 clk) and default mask unless stated.
1. Reset, up_down = 1, start_stop, 125 ticks → number = 16'h0125, running = 1; start_stop → running = 0, count frozen for 50 cycles.
2. Count up from load 16'h5998 (digit 3 base-6), 1 tick → 16'h5999; next tick with SATURATE = 1 → holds 16'h5999, expired pulse exactly 1 cycle, state EXPIRED; further start_stop ignored.
3. Same as 2 with SATURATE = 0 → count wraps to 16'h0000, overflow pulses 1 cycle, running stays 1.
4. load 16'h0003, up_down = 0, start_stop, 3 ticks → 0002, 0001, 0000 with expired pulse on the last; clear → IDLE, number = 0; start_stop with up_down = 0 ignored.
5. Running at 16'h0040: lap → number held at 0040 for 20 ticks while the internal count reaches 0060; lap again → number = 0060 next cycle.
6. clear, load and start_stop asserted in the same cycle → IDLE, count = 0, lap_active = 0; rst_n pulsed low mid-tick asynchronously → all outputs 0 immediately, prescaler restarts from 0.
